// File: rtl/lock_entry_controller.sv
// rtl/lock_entry_controller.sv - key-press to code sequencer with timeout and lockout for the lock core
module lock_entry_controller #(
    parameter int NUM_KEYS       = 4,
    parameter int CODE_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 50,
    parameter int LOCKOUT_CYCLES = 200,
    parameter int CNT_W          = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_KEYS-1:0]     KEY,
    input  logic                    code_ready,
    input  logic                    freeze,
    output logic [2*CODE_LEN-1:0]   code,
    output logic                    code_valid,
    output logic [2:0]              digit_count,
    output logic                    entry_timeout,
    output logic                    lockout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PRESENT = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    localparam logic [NUM_KEYS-1:0] KEY_ONE = 1;

    state_t                  r_state;
    logic [NUM_KEYS-1:0]     r_key_s1;
    logic [NUM_KEYS-1:0]     r_key_s2;
    logic [CNT_W-1:0]        r_timer;
    logic [CNT_W-1:0]        r_lock_cnt;
    logic [2*CODE_LEN-1:0]   r_code;
    logic                    r_code_valid;
    logic [2:0]              r_digit_count;
    logic                    r_entry_timeout;
    logic                    r_lockout;

    logic                    w_onehot;
    logic                    w_press;
    logic [1:0]              w_digit;
    logic [2*CODE_LEN-1:0]   w_code_next;

    // A press is a one-hot key level seen the cycle after all keys were released.
    assign w_onehot = (r_key_s1 != '0) && ((r_key_s1 & (r_key_s1 - KEY_ONE)) == '0);
    assign w_press  = w_onehot && (r_key_s2 == '0);

    always_comb begin
        w_digit = 2'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (r_key_s1[i]) begin
                w_digit = 2'(i);
            end
        end
    end

    always_comb begin
        w_code_next = r_code;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (r_digit_count == 3'(i)) begin
                w_code_next[2*(CODE_LEN-1-i) +: 2] = w_digit;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_key_s1        <= '0;
            r_key_s2        <= '0;
            r_timer         <= '0;
            r_lock_cnt      <= '0;
            r_code          <= '0;
            r_code_valid    <= 1'b0;
            r_digit_count   <= 3'd0;
            r_entry_timeout <= 1'b0;
            r_lockout       <= 1'b0;
        end else begin
            r_key_s1        <= KEY;
            r_key_s2        <= r_key_s1;
            r_entry_timeout <= 1'b0;
            if (freeze) begin
                r_state       <= S_LOCKOUT;
                r_lock_cnt    <= CNT_W'(LOCKOUT_CYCLES - 1);
                r_timer       <= '0;
                r_code        <= '0;
                r_code_valid  <= 1'b0;
                r_digit_count <= 3'd0;
                r_lockout     <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE, S_COLLECT: begin
                        if (w_press) begin
                            r_code        <= w_code_next;
                            r_digit_count <= r_digit_count + 3'd1;
                            r_timer       <= '0;
                            if (r_digit_count == 3'(CODE_LEN - 1)) begin
                                r_state      <= S_PRESENT;
                                r_code_valid <= 1'b1;
                            end else begin
                                r_state <= S_COLLECT;
                            end
                        end else if (r_state == S_COLLECT) begin
                            if (r_timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                                r_state         <= S_IDLE;
                                r_timer         <= '0;
                                r_code          <= '0;
                                r_digit_count   <= 3'd0;
                                r_entry_timeout <= 1'b1;
                            end else begin
                                r_timer <= r_timer + CNT_W'(1);
                            end
                        end
                    end
                    S_PRESENT: begin
                        if (code_ready) begin
                            r_state       <= S_IDLE;
                            r_code        <= '0;
                            r_code_valid  <= 1'b0;
                            r_digit_count <= 3'd0;
                        end
                    end
                    S_LOCKOUT: begin
                        if (r_lock_cnt == '0) begin
                            r_state   <= S_IDLE;
                            r_lockout <= 1'b0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt - CNT_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign code          = r_code;
    assign code_valid    = r_code_valid;
    assign digit_count   = r_digit_count;
    assign entry_timeout = r_entry_timeout;
    assign lockout       = r_lockout;

endmodule

// File: tb/tb_lock_entry_controller.sv
// tb/tb_lock_entry_controller.sv - bench for lock_entry_controller
module tb_lock_entry_controller;

    localparam int NUM_KEYS       = 4;
    localparam int CODE_LEN       = 4;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int LOCKOUT_CYCLES = 200;

    logic        clock;
    logic        reset;
    logic [3:0]  KEY;
    logic        code_ready;
    logic        freeze;
    logic [7:0]  code;
    logic        code_valid;
    logic [2:0]  digit_count;
    logic        entry_timeout;
    logic        lockout;

    int n_chk = 0;
    int n_err = 0;

    lock_entry_controller #(
        .NUM_KEYS(NUM_KEYS),
        .CODE_LEN(CODE_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .KEY(KEY),
        .code_ready(code_ready),
        .freeze(freeze),
        .code(code),
        .code_valid(code_valid),
        .digit_count(digit_count),
        .entry_timeout(entry_timeout),
        .lockout(lockout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: digits typed so far, remaining lockout cycles, idle cycles since last digit.
    logic [3:0] m_k1, m_k2;
    int         m_digits[$];
    bit         m_present;
    int         m_lock_left;
    int         m_idle;
    bit         m_to;

    function automatic bit is_onehot(input logic [3:0] k);
        return (k != 4'd0) && ((k & (k - 4'd1)) == 4'd0);
    endfunction

    function automatic int key_index(input logic [3:0] k);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (k[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        m_k1 = 4'd0;
        m_k2 = 4'd0;
        m_digits.delete();
        m_present = 1'b0;
        m_lock_left = 0;
        m_idle = 0;
        m_to = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] k, input logic rdy, input logic frz);
        bit press;
        int dig;
        if (!reset) begin
            model_reset();
            return;
        end
        press = is_onehot(m_k1) && (m_k2 == 4'd0);
        dig   = key_index(m_k1);
        m_k2  = m_k1;
        m_k1  = k;
        m_to  = 1'b0;
        if (frz) begin
            m_lock_left = LOCKOUT_CYCLES;
            m_digits.delete();
            m_present = 1'b0;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (m_present) begin
            if (rdy) begin
                m_digits.delete();
                m_present = 1'b0;
            end
        end else if (press) begin
            m_digits.push_back(dig);
            m_idle = 0;
            if (m_digits.size() == CODE_LEN) m_present = 1'b1;
        end else if (m_digits.size() > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYCLES) begin
                m_digits.delete();
                m_to = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] model_code();
        logic [7:0] c = 8'd0;
        foreach (m_digits[i]) c = c | (8'(m_digits[i]) << (2 * (CODE_LEN - 1 - i)));
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("code", 32'(code), 32'(model_code()));
        chk("code_valid", 32'(code_valid), 32'(m_present));
        chk("digit_count", 32'(digit_count), 32'(m_digits.size()));
        chk("entry_timeout", 32'(entry_timeout), 32'(m_to));
        chk("lockout", 32'(lockout), 32'(m_lock_left > 0));
    endtask

    task automatic step(input logic [3:0] k, input logic rdy, input logic frz);
        KEY = k;
        code_ready = rdy;
        freeze = frz;
        @(posedge clock);
        model_edge(k, rdy, frz);
        @(negedge clock);
        compare_all();
    endtask

    task automatic press_key(input logic [3:0] k);
        step(k, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'd0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        press_key(a);
        press_key(b);
        press_key(c);
        press_key(d);
    endtask

    task automatic async_reset_check(input string tag);
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk({tag, "_code"}, 32'(code), 32'd0);
        chk({tag, "_valid"}, 32'(code_valid), 32'd0);
        chk({tag, "_count"}, 32'(digit_count), 32'd0);
        chk({tag, "_lockout"}, 32'(lockout), 32'd0);
        step(4'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    int n_pulse;
    int n_hi;
    logic [3:0] rk;

    initial begin
        reset = 1'b0;
        KEY = 4'd0;
        code_ready = 1'b0;
        freeze = 1'b0;
        model_reset();
        @(negedge clock);
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        chk("reset_code", 32'(code), 32'd0);
        chk("reset_count", 32'(digit_count), 32'd0);
        reset = 1'b1;
        step(4'd0, 1'b0, 1'b0);

        // Normal entry, code held until handshake
        enter_code(4'b1000, 4'b0100, 4'b0010, 4'b0001);
        chk("entry_code", 32'(code), 32'hE4);
        chk("entry_valid", 32'(code_valid), 32'd1);
        chk("entry_count", 32'(digit_count), 32'd4);
        press_key(4'b0100);
        chk("present_hold", 32'(code), 32'hE4);
        step(4'd0, 1'b1, 1'b0);
        chk("handshake_valid", 32'(code_valid), 32'd0);
        chk("handshake_count", 32'(digit_count), 32'd0);

        // Illegal chord then a held key: one digit only
        step(4'b1100, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(4'b0010, 1'b0, 1'b0);
        chk("held_count", 32'(digit_count), 32'd1);
        chk("held_digit", 32'(code[7:6]), 32'd1);

        // Inactivity timeout
        n_pulse = 0;
        for (int i = 0; i < 60; i++) begin
            step(4'd0, 1'b0, 1'b0);
            if (entry_timeout) n_pulse++;
        end
        chk("timeout_pulses", 32'(n_pulse), 32'd1);
        chk("timeout_count", 32'(digit_count), 32'd0);
        press_key(4'b0100);
        chk("restart_count", 32'(digit_count), 32'd1);
        chk("restart_slot0", 32'(code[7:6]), 32'd2);

        // Freeze during entry, re-freeze 100 cycles in
        n_hi = 0;
        for (int i = 0; i < 400; i++) begin
            rk = (i < 290 && i % 2 == 0) ? (4'b0001 << ((i / 2) % 4)) : 4'd0;
            step(rk, 1'b0, (i == 0 || i == 100));
            if (lockout) n_hi++;
            else break;
        end
        chk("lockout_len", 32'(n_hi), 32'd300);
        chk("lockout_count", 32'(digit_count), 32'd0);
        step(4'd0, 1'b0, 1'b0);
        enter_code(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        chk("post_lock_code", 32'(code), 32'h1B);
        chk("post_lock_valid", 32'(code_valid), 32'd1);
        step(4'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-entry and in PRESENT
        press_key(4'b1000);
        press_key(4'b1000);
        async_reset_check("rst_mid");
        enter_code(4'b0010, 4'b0010, 4'b1000, 4'b0100);
        chk("rst_present_valid", 32'(code_valid), 32'd1);
        async_reset_check("rst_present");
        enter_code(4'b1000, 4'b0001, 4'b0001, 4'b0010);
        chk("after_rst_code", 32'(code), 32'hC1);
        step(4'd0, 1'b1, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50) rk = 4'd0;
            else if (r < 85) rk = 4'b0001 << $urandom_range(0, 3);
            else rk = 4'($urandom_range(0, 15));
            step(rk, ($urandom_range(0, 99) < 30), ($urandom_range(0, 499) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lock_entry_controller.md
Name: lock_entry_controller

Overview:
- Front-end sequencer for the digital lock core.
- Converts raw KEY presses into complete CODE_LEN-digit codes and presents each code to the lock FSM over a valid/ready handshake.
- Enforces an inactivity timeout between digits and a lockout period after the core signals a freeze.
- Sits between the board KEY inputs and the lock core, and supplies a digit counter to the seven-segment display logic.

Parameters:
- NUM_KEYS, 4, number of key inputs (one digit value per key).
- CODE_LEN, 4, digits per code.
- TIMEOUT_CYCLES, 50, idle cycles allowed between digits before the partial entry is discarded.
- LOCKOUT_CYCLES, 200, cycles key entry stays disabled after a freeze.
- CNT_W, 16, width of the internal timeout and lockout counters (must hold both cycle constants).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- KEY  in  NUM_KEYS  raw key levels, active-high; a legal press is one-hot.
- code_ready  in  1  lock core accepts the presented code.
- freeze  in  1  single-cycle pulse from the core: max wrong attempts reached.
- code  out  2*CODE_LEN  packed digits; first digit in the MSBs, 2 bits per digit.
- code_valid  out  1  code is complete and stable.
- digit_count  out  3  digits captured so far (0..CODE_LEN).
- entry_timeout  out  1  one-cycle pulse when a partial entry is discarded.
- lockout  out  1  high while key entry is disabled.

Behaviour:
- Reset values (reset low): all outputs 0, state IDLE, both key registers 0, both counters 0.
- Key capture:
  - key_s1 <= KEY and key_s2 <= key_s1 every edge.
  - press = (key_s1 one-hot) && (key_s2 == 0).
  - Digit value = index of the set bit (KEY[3]=3 ... KEY[0]=0).
  - Non-one-hot or held keys generate no press.
- Latency: KEY sampled high at edge N → digit stored and digit_count incremented at edge N+1.
- States: IDLE, COLLECT, PRESENT, LOCKOUT; state register binary-encoded.
- IDLE:
  - digit_count = 0.
  - A press stores slot 0, sets digit_count to 1, clears the timer, and moves to COLLECT.
- COLLECT:
  - Each press stores the digit at slot digit_count, increments the count, and clears the timer.
  - Otherwise the timer increments.
  - The edge that stores digit CODE_LEN moves to PRESENT; code_valid is high from that edge.
  - If the timer reaches TIMEOUT_CYCLES-1 with no press: clear code and digit_count, pulse entry_timeout for 1 cycle, go to IDLE.
- PRESENT:
  - code_valid = 1, code held stable, presses ignored (not queued).
  - code_valid && code_ready at an edge: clear code and digit_count, go to IDLE.
  - code_valid must not drop before the handshake completes.
- LOCKOUT:
  - Entered from any state on freeze = 1: load counter = LOCKOUT_CYCLES-1, clear code, digit_count and code_valid.
  - lockout = 1; presses ignored.
  - Counter decrements each cycle; at 0 go to IDLE and deassert lockout on that edge.
  - A freeze received during LOCKOUT reloads the counter.
- Priority (same cycle): freeze > handshake > timeout > press.
  - A press coincident with the handshake is dropped.
  - The timeout and press conditions are exclusive by construction.
- digit_count saturates at CODE_LEN; it never wraps.
- Reset asserted mid-entry or mid-lockout returns immediately (asynchronously) to the reset values.
- Sequential logic is registered only; no latches.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release → code=0, code_valid=0, lockout=0, digit_count=0.
- Normal entry: KEY=1000,0100,0010,0001, each 1 cycle then 0 for 5 cycles, with code_ready=0 → digit_count steps 1..4, code=8'b11_10_01_00, code_valid stays 1. Then code_ready=1 for 1 cycle → code_valid=0, digit_count=0 next edge.
- Illegal and held keys: KEY=1100 for 1 cycle, then KEY=0010 held 10 cycles → exactly one digit captured (digit_count=1, code[7:6]=01).
- Timeout: one press, then idle 50 cycles → entry_timeout high for exactly 1 cycle, digit_count=0, state IDLE; a further press restarts at slot 0.
- Lockout: freeze pulse during COLLECT → lockout=1 for 200 cycles, presses ignored. A second freeze at cycle 100 extends lockout to 300 total cycles. Afterward, a 4-key entry completes normally.
- Mid-operation reset: assert reset after 2 digits, or during PRESENT → all outputs 0 immediately. After release, a full code entry succeeds.
